// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: EX write-back triple, valid bit, occupancy counters.
// Latency: 1 cycle, every output comes straight from a flop.
// Backpressure: stall vector from ctrl; MEM stall holds, EX-only stall inserts a bubble, flush clears.
module ex_mem_reg #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int STALL_WIDTH = 6,
  parameter int EX_BIT      = 3,
  parameter int MEM_BIT     = 4,
  parameter int BCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  ex_waddr_i,
  input  logic                   ex_we_i,
  input  logic [DATA_WIDTH-1:0]  ex_wdata_i,
  output logic [ADDR_WIDTH-1:0]  mem_waddr_o,
  output logic                   mem_we_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  output logic                   mem_valid_o,
  output logic [31:0]            wb_cnt_o,
  output logic [BCNT_WIDTH-1:0]  bubble_cnt_o
);

  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_valid;
  logic [31:0]           r_wb_cnt;
  logic [BCNT_WIDTH-1:0] r_bubble_cnt;

  logic w_hold;
  logic w_bubble;
  logic w_load;
  logic w_bcnt_max;
  logic w_unused_stall;

  // MEM stall dominates: a MEM stall holds even if EX is not stalled, so no
  // EX result can be dropped or captured twice.
  assign w_hold     = stall_i[MEM_BIT];
  assign w_bubble   = stall_i[EX_BIT] & ~stall_i[MEM_BIT];
  assign w_load     = ~stall_i[EX_BIT] & ~stall_i[MEM_BIT];
  assign w_bcnt_max = &r_bubble_cnt;

  // Only the EX and MEM stall bits matter here; the rest are deliberately ignored.
  assign w_unused_stall = ^stall_i;

  // Slot register: reset/flush/bubble clear it, hold keeps it, load captures EX.
  always_ff @(posedge clk) begin
    if (rst || flush_i || w_bubble) begin
      r_waddr <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      // waddr/wdata are captured even when we=0; consumers qualify with mem_we_o.
      r_waddr <= ex_waddr_i;
      r_we    <= ex_we_i;
      r_wdata <= ex_wdata_i;
      r_valid <= 1'b1;
    end else if (w_hold) begin
      r_waddr <= r_waddr;
      r_we    <= r_we;
      r_wdata <= r_wdata;
      r_valid <= r_valid;
    end
  end

  // Write-back counter: counts loads that carry a register write, wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_cnt <= '0;
    end else if (!flush_i && w_load && ex_we_i) begin
      r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  // Bubble counter: counts bubble insertions, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!flush_i && w_bubble && !w_bcnt_max) begin
      r_bubble_cnt <= r_bubble_cnt + {{(BCNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign mem_waddr_o  = r_waddr;
  assign mem_we_o     = r_we;
  assign mem_wdata_o  = r_wdata;
  assign mem_valid_o  = r_valid;
  assign wb_cnt_o     = r_wb_cnt;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed scenarios plus randomized traffic.
// Latency: outputs compared one cycle after the sampling edge.
// Backpressure: stall vector and flush driven directly by the bench.
module tb_ex_mem_reg;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int SW   = 6;
  localparam int BW   = 8;
  localparam int BMAX = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall_i;
  logic          flush_i;
  logic [AW-1:0] ex_waddr_i;
  logic          ex_we_i;
  logic [DW-1:0] ex_wdata_i;
  logic [AW-1:0] mem_waddr_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_valid_o;
  logic [31:0]   wb_cnt_o;
  logic [BW-1:0] bubble_cnt_o;

  ex_mem_reg #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STALL_WIDTH(SW),
    .EX_BIT(3), .MEM_BIT(4), .BCNT_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_waddr_i(ex_waddr_i), .ex_we_i(ex_we_i), .ex_wdata_i(ex_wdata_i),
    .mem_waddr_o(mem_waddr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_o(mem_valid_o), .wb_cnt_o(wb_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: what the slot and counters must hold.
  int unsigned m_waddr, m_we, m_wdata, m_valid;
  longint unsigned m_wb;
  int unsigned m_bub;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: apply the per-edge priority rules with plain arithmetic.
  always @(posedge clk) begin
    if (rst) begin
      m_waddr = 0; m_we = 0; m_wdata = 0; m_valid = 0; m_wb = 0; m_bub = 0;
    end else if (flush_i) begin
      m_waddr = 0; m_we = 0; m_wdata = 0; m_valid = 0;
    end else if (stall_i[4]) begin
      // hold: nothing changes
    end else if (stall_i[3]) begin
      m_waddr = 0; m_we = 0; m_wdata = 0; m_valid = 0;
      if (m_bub < BMAX) m_bub = m_bub + 1;
    end else begin
      m_waddr = ex_waddr_i; m_we = ex_we_i; m_wdata = ex_wdata_i; m_valid = 1;
      if (ex_we_i) m_wb = (m_wb + 1) % 64'h1_0000_0000;
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("waddr", 32'(mem_waddr_o), m_waddr);
      cmp("we", 32'(mem_we_o), m_we);
      cmp("wdata", mem_wdata_o, m_wdata);
      cmp("valid", 32'(mem_valid_o), m_valid);
      cmp("wb_cnt", wb_cnt_o, m_wb[31:0]);
      cmp("bubble_cnt", 32'(bubble_cnt_o), m_bub);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [SW-1:0] st, input logic fl,
                       input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    stall_i = st; flush_i = fl; ex_waddr_i = a; ex_we_i = we; ex_wdata_i = d;
  endtask

  // Literal expectations that pin the model to hand-computed values.
  task automatic expect_out(input string tag, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] d, input logic v,
                            input logic [31:0] wb, input logic [BW-1:0] bub);
    cmp({tag, ".waddr"}, 32'(mem_waddr_o), 32'(a));
    cmp({tag, ".we"}, 32'(mem_we_o), 32'(we));
    cmp({tag, ".wdata"}, mem_wdata_o, d);
    cmp({tag, ".valid"}, 32'(mem_valid_o), 32'(v));
    cmp({tag, ".wb_cnt"}, wb_cnt_o, wb);
    cmp({tag, ".bubble_cnt"}, 32'(bubble_cnt_o), 32'(bub));
  endtask

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, '0, 1'b0, '0);
    cyc();
    chk_en = 1'b1;
    cyc();
    expect_out("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'd0, 8'd0);

    // First load right after reset release.
    rst = 1'b0;
    drive(6'b000000, 1'b0, 5'd3, 1'b1, 32'h12345678);
    cyc();
    expect_out("first_load", 5'd3, 1'b1, 32'h12345678, 1'b1, 32'd1, 8'd0);

    // Hold for 3 cycles while inputs change.
    drive(6'b000000, 1'b0, 5'd7, 1'b1, 32'hAAAA5555);
    cyc();
    drive(6'b011111, 1'b0, 5'd9, 1'b1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("hold", 5'd7, 1'b1, 32'hAAAA5555, 1'b1, 32'd2, 8'd0);
    end

    // Two bubbles.
    drive(6'b001111, 1'b0, 5'd9, 1'b1, 32'h1);
    cyc();
    expect_out("bubble1", 5'd0, 1'b0, 32'h0, 1'b0, 32'd2, 8'd1);
    cyc();
    expect_out("bubble2", 5'd0, 1'b0, 32'h0, 1'b0, 32'd2, 8'd2);

    // Flush outranks hold.
    drive(6'b000000, 1'b0, 5'd4, 1'b1, 32'hFF);
    cyc();
    expect_out("pre_flush", 5'd4, 1'b1, 32'hFF, 1'b1, 32'd3, 8'd2);
    drive(6'b111111, 1'b1, 5'd4, 1'b1, 32'hFF);
    cyc();
    expect_out("flush", 5'd0, 1'b0, 32'h0, 1'b0, 32'd3, 8'd2);

    // Overflow-gated load: valid but no write, fields captured verbatim.
    drive(6'b000000, 1'b0, 5'd10, 1'b0, 32'h80000000);
    cyc();
    expect_out("no_we_load", 5'd10, 1'b0, 32'h80000000, 1'b1, 32'd3, 8'd2);

    // Illegal combo (EX running, MEM stalled) must hold.
    drive(6'b010000, 1'b0, 5'd11, 1'b1, 32'h5);
    cyc();
    expect_out("mem_only_stall", 5'd10, 1'b0, 32'h80000000, 1'b1, 32'd3, 8'd2);

    // Reset in the middle of a hold clears everything.
    rst = 1'b1;
    cyc();
    expect_out("rst_mid_hold", 5'd0, 1'b0, 32'h0, 1'b0, 32'd0, 8'd0);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [SW-1:0] st;
      r  = $urandom;
      st = SW'($urandom);
      st[4] = ($urandom_range(0, 3) == 0);
      st[3] = st[4] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      drive(st, ($urandom_range(0, 15) == 0), AW'(r), r[31], DW'($urandom));
      cyc();
    end
    rst = 1'b0;

    // Bubble counter saturation.
    drive(6'b001000, 1'b0, 5'd1, 1'b1, 32'h1);
    for (int i = 0; i < BMAX + 20; i++) cyc();
    cmp("bubble_sat", 32'(bubble_cnt_o), 32'h000000FF);

    // wb counter wrap: preload all-ones, then one counted load.
    m_wb = 64'hFFFF_FFFF;
    force dut.r_wb_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_wb_cnt;
    drive(6'b000000, 1'b0, 5'd2, 1'b1, 32'hCAFE);
    cyc();
    cmp("wb_wrap", wb_cnt_o, 32'h0);
    cmp("bubble_after_wrap", 32'(bubble_cnt_o), 32'h000000FF);
    drive(6'b001000, 1'b0, 5'd2, 1'b1, 32'hCAFE);
    cyc();
    cmp("bubble_stays_sat", 32'(bubble_cnt_o), 32'h000000FF);
    cmp("wb_after_bubble", wb_cnt_o, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
